sobel_window_buffer: RTL and testbench

// - Streaming 3x3 neighbourhood generator that feeds the Sobel gradient stage.
// - Accepts raster-order pixels (one per handshake), holds two previous image rows in line buffers, emits a registered 3x3 window.
// - Tracks row/col position itself and pulses frame_done after the last pixel of a frame.

---
 rtl/sobel_pkg.sv | 29 ++
 rtl/sobel_line_buffer.sv | 39 +++
 rtl/sobel_window_buffer.sv | 152 +++++++++++++++
 tb/tb_sobel_window_buffer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel pipeline: pixel and 3x3 window representations,
// plus the pack/unpack helpers that the gradient stage also relies on.
package sobel_pkg;

   localparam int PIX_BITS  = 8;
   localparam int WIN_TAPS  = 9;

   typedef logic [PIX_BITS-1:0] pixel_t;
   typedef pixel_t window_t [0:WIN_TAPS-1];

   // Flatten a window into the row-major bus layout (slot 0 in the LSBs).
   function automatic logic [WIN_TAPS*PIX_BITS-1:0] pack_window(input window_t w);
      logic [WIN_TAPS*PIX_BITS-1:0] v;
      for (int k = 0; k < WIN_TAPS; k++) begin
         v[k*PIX_BITS +: PIX_BITS] = w[k];
      end
      return v;
   endfunction

   // Inverse of pack_window.
   function automatic window_t unpack_window(input logic [WIN_TAPS*PIX_BITS-1:0] v);
      window_t w;
      for (int k = 0; k < WIN_TAPS; k++) begin
         w[k] = v[k*PIX_BITS +: PIX_BITS];
      end
      return w;
   endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// Fixed-length delay line: dout is the value presented on din exactly DEPTH
// enabled shifts earlier. Holds one image row between window rows.
module sobel_line_buffer
   import sobel_pkg::*;
#(
   parameter int DEPTH = 640,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             shift_en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   // Next contents: shift one place toward the output when enabled.
   always_comb begin
      // NOTE: default every comb output first so no path leaves it unassigned (no latch).
      mem_d = mem_q;
      if (shift_en) begin
         mem_d[0] = din;
         for (int i = 1; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i-1];
         end
      end
   end

   // Storage register; contents are meaningless until a full row has passed.
   always_ff @(posedge clk) begin
      // NOTE: storage arrays carry no reset so they map onto plain flops/RAM; <= keeps
      // every flop sampling pre-edge values.
      mem_q <= mem_d;
   end

   assign dout = mem_q[DEPTH-1];

endmodule

// File: rtl/sobel_window_buffer.sv
// Streaming 3x3 neighbourhood generator: two line buffers feed a 3x3 register
// window; a registered output stage with valid/ready handshake presents each
// complete window together with the image position of its centre.
module sobel_window_buffer
   import sobel_pkg::*;
#(
   parameter int PIX_BITS   = 8,
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int CNT_BITS   = 10
) (
   input  logic                     clk,
   input  logic                     n_rst,
   input  logic                     clear,
   input  logic                     pix_valid,
   input  logic [PIX_BITS-1:0]      pix_data,
   output logic                     pix_ready,
   output logic                     win_valid,
   input  logic                     win_ready,
   output logic [9*PIX_BITS-1:0]    win_data,
   output logic [CNT_BITS-1:0]      win_row,
   output logic [CNT_BITS-1:0]      win_col,
   output logic                     frame_done
);

   localparam logic [CNT_BITS-1:0] COL_LAST = CNT_BITS'(IMG_WIDTH - 1);
   localparam logic [CNT_BITS-1:0] ROW_LAST = CNT_BITS'(IMG_HEIGHT - 1);
   localparam logic [CNT_BITS-1:0] ONE      = CNT_BITS'(1);
   localparam logic [CNT_BITS-1:0] TWO      = CNT_BITS'(2);

   logic                    accept, take, produce, last_col, last_row;
   logic [PIX_BITS-1:0]     lb0_dout, lb1_dout;
   logic [PIX_BITS-1:0]     tap_q [WIN_TAPS];
   logic [PIX_BITS-1:0]     tap_d [WIN_TAPS];
   logic [CNT_BITS-1:0]     row_q, row_d, col_q, col_d;
   logic [CNT_BITS-1:0]     win_row_q, win_row_d, win_col_q, win_col_d;
   logic [9*PIX_BITS-1:0]   win_data_q, win_data_d;
   logic                    win_valid_q, win_valid_d;
   logic                    frame_done_q, frame_done_d;

   // Handshake: a held window blocks input until it is consumed; clear drops any accept.
   assign pix_ready = ~win_valid_q | win_ready;
   assign accept    = pix_valid & pix_ready;
   assign take      = accept & ~clear;
   assign last_col  = (col_q == COL_LAST);
   assign last_row  = (row_q == ROW_LAST);
   assign produce   = (row_q >= TWO) && (col_q >= TWO);

   sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_BITS)) u_lb0 (
      .clk      (clk),
      .shift_en (take),
      .din      (pix_data),
      .dout     (lb0_dout)
   );

   sobel_line_buffer #(.DEPTH(IMG_WIDTH), .WIDTH(PIX_BITS)) u_lb1 (
      .clk      (clk),
      .shift_en (take),
      .din      (lb0_dout),
      .dout     (lb1_dout)
   );

   // Window shift: columns move left, new column = {row-2, row-1, current} pixels.
   always_comb begin
      tap_d = tap_q;
      if (take) begin
         tap_d[0] = tap_q[1];
         tap_d[1] = tap_q[2];
         tap_d[2] = lb1_dout;
         tap_d[3] = tap_q[4];
         tap_d[4] = tap_q[5];
         tap_d[5] = lb0_dout;
         tap_d[6] = tap_q[7];
         tap_d[7] = tap_q[8];
         tap_d[8] = pix_data;
      end
   end

   // Raster position of the next pixel; wraps by compare-to-limit.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (clear) begin
         row_d = '0;
         col_d = '0;
      end else if (take) begin
         if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + ONE;
         end else begin
            col_d = col_q + ONE;
         end
      end
   end

   // Output stage: load the freshly shifted window when it is complete, else drain.
   always_comb begin
      win_valid_d  = win_valid_q;
      win_data_d   = win_data_q;
      win_row_d    = win_row_q;
      win_col_d    = win_col_q;
      frame_done_d = 1'b0;
      if (clear) begin
         win_valid_d = 1'b0;
      end else if (take) begin
         win_valid_d  = produce;
         frame_done_d = last_row & last_col;
         if (produce) begin
            for (int k = 0; k < WIN_TAPS; k++) begin
               win_data_d[k*PIX_BITS +: PIX_BITS] = tap_d[k];
            end
            win_row_d = row_q - ONE;
            win_col_d = col_q - ONE;
         end
      end else if (win_ready) begin
         win_valid_d = 1'b0;
      end
   end

   // Window taps hold only image data, so they need no reset.
   always_ff @(posedge clk) begin
      tap_q <= tap_d;
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         row_q        <= '0;
         col_q        <= '0;
         win_valid_q  <= 1'b0;
         win_data_q   <= '0;
         win_row_q    <= '0;
         win_col_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         row_q        <= row_d;
         col_q        <= col_d;
         win_valid_q  <= win_valid_d;
         win_data_q   <= win_data_d;
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign win_valid  = win_valid_q;
   assign win_data   = win_data_q;
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Directed bench for sobel_window_buffer on a 4x4 image.
module tb_sobel_window_buffer;
   import sobel_pkg::*;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        clear;
   logic        pix_valid;
   logic [7:0]  pix_data;
   logic        pix_ready;
   logic        win_valid;
   logic        win_ready;
   logic [71:0] win_data;
   logic [9:0]  win_row;
   logic [9:0]  win_col;
   logic        frame_done;

   int vectors     = 0;
   int miscompares = 0;
   int nwin        = 0;
   int ndone       = 0;

   sobel_window_buffer #(
      .PIX_BITS   (8),
      .IMG_WIDTH  (4),
      .IMG_HEIGHT (4),
      .CNT_BITS   (10)
   ) dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .clear      (clear),
      .pix_valid  (pix_valid),
      .pix_data   (pix_data),
      .pix_ready  (pix_ready),
      .win_valid  (win_valid),
      .win_ready  (win_ready),
      .win_data   (win_data),
      .win_row    (win_row),
      .win_col    (win_col),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Golden window for centre (r-1, c-1) where pixel value = base + row*4 + col.
   function automatic logic [71:0] exp_window(input logic [7:0] base, input int r, input int c);
      window_t w;
      for (int k = 0; k < 9; k++) begin
         w[k] = base + 8'((r - 2 + k / 3) * 4 + (c - 2 + k % 3));
      end
      return pack_window(w);
   endfunction

   // Offer one pixel at (r,c), expecting it to be accepted at the next edge.
   task automatic send(input logic [7:0] base, input int r, input int c);
      logic exp_win;
      exp_win   = (r >= 2) && (c >= 2);
      pix_valid = 1'b1;
      pix_data  = base + 8'(r * 4 + c);
      #1;
      chk("pix_ready", 72'(pix_ready), 72'(1));
      @(posedge clk); #1;
      pix_valid = 1'b0;
      chk("win_valid", 72'(win_valid), 72'(exp_win));
      chk("frame_done", 72'(frame_done), 72'((r == 3) && (c == 3)));
      if (exp_win) begin
         nwin++;
         chk("win_data", win_data, exp_window(base, r, c));
         chk("win_row", 72'(win_row), 72'(r - 1));
         chk("win_col", 72'(win_col), 72'(c - 1));
      end
      if (frame_done) ndone++;
   endtask

   task automatic idle();
      pix_valid = 1'b0;
      @(posedge clk); #1;
      chk("idle_win_valid", 72'(win_valid), 72'(0));
      chk("idle_frame_done", 72'(frame_done), 72'(0));
   endtask

   task automatic send_frame(input logic [7:0] base, input bit gaps, input int count);
      for (int p = 0; p < count; p++) begin
         if (gaps && ($urandom_range(0, 1) == 1)) idle();
         send(base, p / 4, p % 4);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      n_rst     = 1'b0;
      clear     = 1'b0;
      pix_valid = 1'b0;
      pix_data  = '0;
      win_ready = 1'b1;
      #2;
      chk("rst_pix_ready", 72'(pix_ready), 72'(1));
      chk("rst_win_valid", 72'(win_valid), 72'(0));
      chk("rst_frame_done", 72'(frame_done), 72'(0));
      chk("rst_win_data", win_data, 72'(0));
      chk("rst_win_row", 72'(win_row), 72'(0));
      chk("rst_win_col", 72'(win_col), 72'(0));
      #10 n_rst = 1'b1;
      @(posedge clk); #1;

      // Frame 1 with a 5-cycle backpressure hold after the first window.
      nwin = 0; ndone = 0;
      send_frame(8'h00, 1'b0, 11);
      pix_valid = 1'b1;
      pix_data  = 8'd11;
      win_ready = 1'b0;
      repeat (5) begin
         #1;
         chk("bp_pix_ready", 72'(pix_ready), 72'(0));
         chk("bp_win_valid", 72'(win_valid), 72'(1));
         chk("bp_win_data", win_data, exp_window(8'h00, 2, 2));
         @(posedge clk); #1;
      end
      win_ready = 1'b1;
      for (int p = 11; p < 16; p++) send(8'h00, p / 4, p % 4);
      chk("f1_windows", 72'(nwin), 72'(4));
      chk("f1_done", 72'(ndone), 72'(1));

      // Two back-to-back frames with random input gaps.
      nwin = 0; ndone = 0;
      send_frame(8'h40, 1'b1, 16);
      send_frame(8'h80, 1'b1, 16);
      chk("gap_windows", 72'(nwin), 72'(8));
      chk("gap_done", 72'(ndone), 72'(2));

      // Clear after pixel 9, then a fresh frame.
      send_frame(8'h00, 1'b0, 10);
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("clr_win_valid", 72'(win_valid), 72'(0));
      chk("clr_row", 72'(dut.row_q), 72'(0));
      chk("clr_col", 72'(dut.col_q), 72'(0));
      nwin = 0; ndone = 0;
      send_frame(8'h00, 1'b0, 16);
      chk("clr_windows", 72'(nwin), 72'(4));
      chk("clr_done", 72'(ndone), 72'(1));

      // Asynchronous reset mid-row after pixel 6.
      send_frame(8'h00, 1'b0, 7);
      n_rst = 1'b0;
      #2;
      chk("arst_pix_ready", 72'(pix_ready), 72'(1));
      chk("arst_win_valid", 72'(win_valid), 72'(0));
      chk("arst_win_data", win_data, 72'(0));
      chk("arst_win_row", 72'(win_row), 72'(0));
      chk("arst_win_col", 72'(win_col), 72'(0));
      chk("arst_frame_done", 72'(frame_done), 72'(0));
      #3 n_rst = 1'b1;
      @(posedge clk); #1;
      nwin = 0; ndone = 0;
      send_frame(8'h00, 1'b0, 16);
      chk("arst_windows", 72'(nwin), 72'(4));

      // Clear in the same cycle as an accept: the pixel is dropped.
      send_frame(8'h00, 1'b0, 5);
      pix_valid = 1'b1;
      pix_data  = 8'd5;
      clear     = 1'b1;
      @(posedge clk); #1;
      clear     = 1'b0;
      pix_valid = 1'b0;
      chk("clracc_win_valid", 72'(win_valid), 72'(0));
      chk("clracc_row", 72'(dut.row_q), 72'(0));
      chk("clracc_col", 72'(dut.col_q), 72'(0));
      nwin = 0; ndone = 0;
      send_frame(8'h00, 1'b0, 16);
      chk("clracc_windows", 72'(nwin), 72'(4));
      chk("clracc_done", 72'(ndone), 72'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
